// File: rtl/xcvr_pkg.sv
// Shared definitions for the transceiver RX reset sequencer: state encoding,
// retry-counter bound and elaboration-time sizing helpers.
package xcvr_pkg;

  typedef enum logic [2:0] {
    ST_WAIT_PLL   = 3'd0,
    ST_PLL_SETTLE = 3'd1,
    ST_WAIT_CDR   = 3'd2,
    ST_PMA_PULSE  = 3'd3,
    ST_PCS_REL    = 3'd4,
    ST_READY      = 3'd5,
    ST_FAULT      = 3'd6
  } state_e;

  localparam int RETRY_W = 3;

  function automatic bit retry_ok(input int max_retry);
    return (max_retry >= 0) && (max_retry < (1 << RETRY_W));
  endfunction

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/xcvr_rx_reset_seq_if.sv
// Lane-side signal bundle of the RX reset sequencer.
// Signalling: no valid/ready; lock inputs are async levels, force_rst is a clk-synchronous level, all outputs are registered levels.
interface xcvr_rx_reset_seq_if;
  logic       pll_lock;
  logic       cdr_lock;
  logic       force_rst;
  logic       pma_rst_n;
  logic       pcs_rst_n;
  logic       rx_ready;
  logic       fault;
  logic [2:0] retry_cnt;
  logic [2:0] state;

  modport master (
    input  pll_lock, cdr_lock, force_rst,
    output pma_rst_n, pcs_rst_n, rx_ready, fault, retry_cnt, state
  );

  modport slave (
    output pll_lock, cdr_lock, force_rst,
    input  pma_rst_n, pcs_rst_n, rx_ready, fault, retry_cnt, state
  );
endinterface

// File: rtl/lock_filter.sv
// 2-FF synchroniser plus saturating run-length counter for an async lock input.
// Lock is accepted after LOCK_FILT_CYC consecutive synced-high cycles; loss is reported on the first synced low.
module lock_filter
  import xcvr_pkg::*;
#(
  parameter int LOCK_FILT_CYC = 64
) (
  input  logic clk,
  input  logic arst_n,
  input  logic lock_raw,
  output logic locked,
  output logic lost
);

  localparam int CNT_W = clog2(LOCK_FILT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_FILT_CYC);

  logic [1:0]       sync;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      sync <= 2'b00;
      cnt  <= '0;
    end else begin
      sync <= {sync[0], lock_raw};
      if (!sync[1])
        cnt <= '0;
      else if (cnt != CNT_MAX)
        cnt <= cnt + 1'b1;
    end
  end

  assign locked = (cnt == CNT_MAX);
  assign lost   = ~sync[1];

endmodule

// File: rtl/xcvr_rx_reset_seq.sv
// RX bring-up sequencer for one transceiver lane: PLL lock -> PMA release -> CDR lock -> PCS release -> ready,
// with automatic recovery on lock loss and a sticky fault after CDR retries run out.
module xcvr_rx_reset_seq
  import xcvr_pkg::*;
#(
  parameter int PLL_SETTLE_CYC  = 1000,
  parameter int CDR_TIMEOUT_CYC = 100000,
  parameter int LOCK_FILT_CYC   = 64,
  parameter int PMA_PULSE_CYC   = 16,
  parameter int PCS_DLY_CYC     = 16,
  parameter int MAX_RETRY       = 7
) (
  input  logic                 clk,
  input  logic                 arst_n,
  xcvr_rx_reset_seq_if.master  bus
);

  if (!retry_ok(MAX_RETRY)) begin : g_retry_chk
    $error("MAX_RETRY must fit the 3-bit retry counter");
  end

  localparam int MAX_CYC = max2(max2(PLL_SETTLE_CYC, CDR_TIMEOUT_CYC), max2(PMA_PULSE_CYC, PCS_DLY_CYC));
  localparam int TIMER_W = clog2(MAX_CYC) + 1;

  // Each limit is the timer value seen on the last cycle spent in the state.
  localparam logic [TIMER_W-1:0] SETTLE_LAST  = TIMER_W'(PLL_SETTLE_CYC - 1);
  localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(CDR_TIMEOUT_CYC - 1);
  localparam logic [TIMER_W-1:0] PULSE_LAST   = TIMER_W'(PMA_PULSE_CYC - 1);
  localparam logic [TIMER_W-1:0] PCS_LAST     = TIMER_W'(PCS_DLY_CYC - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX    = RETRY_W'(MAX_RETRY);

  logic pll_locked, pll_lost, cdr_locked, cdr_lost;

  lock_filter #(.LOCK_FILT_CYC(LOCK_FILT_CYC)) u_pll_filt (
    .clk(clk), .arst_n(arst_n), .lock_raw(bus.pll_lock), .locked(pll_locked), .lost(pll_lost)
  );

  lock_filter #(.LOCK_FILT_CYC(LOCK_FILT_CYC)) u_cdr_filt (
    .clk(clk), .arst_n(arst_n), .lock_raw(bus.cdr_lock), .locked(cdr_locked), .lost(cdr_lost)
  );

  state_e               state_r, state_nxt;
  logic [TIMER_W-1:0]   timer;
  logic [RETRY_W-1:0]   retry;
  logic                 retry_inc;
  logic                 pma_rel, pcs_rel, ready, fault;

  always_comb begin
    state_nxt = state_r;
    retry_inc = 1'b0;
    case (state_r)
      ST_WAIT_PLL:   if (pll_locked) state_nxt = ST_PLL_SETTLE;
      ST_PLL_SETTLE: if (timer == SETTLE_LAST) state_nxt = ST_WAIT_CDR;
      ST_WAIT_CDR: begin
        if (cdr_locked) begin
          state_nxt = ST_PCS_REL;
        end else if (timer == TIMEOUT_LAST) begin
          if (retry == RETRY_MAX) begin
            state_nxt = ST_FAULT;
          end else begin
            retry_inc = 1'b1;
            state_nxt = ST_PMA_PULSE;
          end
        end
      end
      ST_PMA_PULSE:  if (timer == PULSE_LAST) state_nxt = ST_WAIT_CDR;
      ST_PCS_REL, ST_READY: begin
        if (cdr_lost) begin
          if (retry == RETRY_MAX) begin
            state_nxt = ST_FAULT;
          end else begin
            retry_inc = 1'b1;
            state_nxt = ST_PMA_PULSE;
          end
        end else if (state_r == ST_PCS_REL && timer == PCS_LAST) begin
          state_nxt = ST_READY;
        end
      end
      ST_FAULT:      state_nxt = ST_FAULT;
      default:       state_nxt = ST_WAIT_PLL;
    endcase

    // PLL loss beats CDR events and timeouts; force_rst beats everything.
    if (pll_lost && state_r != ST_WAIT_PLL && state_r != ST_FAULT) begin
      state_nxt = ST_WAIT_PLL;
      retry_inc = 1'b0;
    end
    if (bus.force_rst) begin
      state_nxt = ST_WAIT_PLL;
      retry_inc = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_r <= ST_WAIT_PLL;
      timer   <= '0;
      retry   <= '0;
      pma_rel <= 1'b0;
      pcs_rel <= 1'b0;
      ready   <= 1'b0;
      fault   <= 1'b0;
    end else begin
      state_r <= state_nxt;
      // Timer saturates in untimed states so it can never wrap into a limit.
      if (state_nxt != state_r)
        timer <= '0;
      else if (timer != '1)
        timer <= timer + 1'b1;
      if (state_nxt == ST_WAIT_PLL)
        retry <= '0;
      else if (retry_inc)
        retry <= retry + 1'b1;
      pma_rel <= (state_nxt == ST_WAIT_CDR) || (state_nxt == ST_PCS_REL) || (state_nxt == ST_READY);
      pcs_rel <= (state_nxt == ST_PCS_REL) || (state_nxt == ST_READY);
      ready   <= (state_nxt == ST_READY);
      fault   <= (state_nxt == ST_FAULT);
    end
  end

  assign bus.pma_rst_n = pma_rel;
  assign bus.pcs_rst_n = pcs_rel;
  assign bus.rx_ready  = ready;
  assign bus.fault     = fault;
  assign bus.retry_cnt = retry;
  assign bus.state     = state_r;

endmodule

// File: tb/tb_xcvr_rx_reset_seq.sv
// Self-checking bench for the RX reset sequencer: a vector table for the nominal bring-up and CDR/PLL loss,
// plus hand-written sequences for glitch rejection, retry exhaustion, force reset and async reset.
module tb_xcvr_rx_reset_seq;

  logic clk;
  logic arst_n;

  xcvr_rx_reset_seq_if bus ();

  xcvr_rx_reset_seq #(
    .PLL_SETTLE_CYC (20),
    .CDR_TIMEOUT_CYC(50),
    .LOCK_FILT_CYC  (4),
    .PMA_PULSE_CYC  (3),
    .PCS_DLY_CYC    (5),
    .MAX_RETRY      (2)
  ) dut (
    .clk   (clk),
    .arst_n(arst_n),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  // Expected word: {state[2:0], pma_rst_n, pcs_rst_n, rx_ready, fault, retry_cnt[2:0]}
  logic [9:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic       pll;
    logic       cdr;
    logic       frc;
    int         n;
    logic [2:0] st;
    logic       pma;
    logic       pcs;
    logic       rdy;
    logic       flt;
    logic [2:0] rt;
  } vec_t;

  vec_t vecs[16];

  function automatic logic [9:0] pk(input int st, input int pma, input int pcs,
                                    input int rdy, input int flt, input int rt);
    logic [2:0] s3;
    logic [2:0] r3;
    s3 = 3'(st);
    r3 = 3'(rt);
    return {s3, pma[0], pcs[0], rdy[0], flt[0], r3};
  endfunction

  function automatic vec_t mk(input int pll, input int cdr, input int frc, input int n,
                              input int st, input int pma, input int pcs, input int rdy,
                              input int flt, input int rt);
    vec_t v;
    v.pll = pll[0];
    v.cdr = cdr[0];
    v.frc = frc[0];
    v.n   = n;
    v.st  = 3'(st);
    v.pma = pma[0];
    v.pcs = pcs[0];
    v.rdy = rdy[0];
    v.flt = flt[0];
    v.rt  = 3'(rt);
    return v;
  endfunction

  function automatic logic [9:0] actual();
    return {bus.state, bus.pma_rst_n, bus.pcs_rst_n, bus.rx_ready, bus.fault, bus.retry_cnt};
  endfunction

  task automatic compare(input string tag);
    logic [9:0] e;
    logic [9:0] a;
    e = exp_q.pop_front();
    a = actual();
    n_checks++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got st=%0d pma=%b pcs=%b rdy=%b flt=%b rt=%0d, want st=%0d pma=%b pcs=%b rdy=%b flt=%b rt=%0d",
               tag, a[9:7], a[6], a[5], a[4], a[3], a[2:0], e[9:7], e[6], e[5], e[4], e[3], e[2:0]);
    end
  endtask

  task automatic chk(input string tag, input logic [9:0] e);
    exp_q.push_back(e);
    compare(tag);
  endtask

  // ---------------- driver tasks ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(input logic pll, input logic cdr, input logic frc);
    bus.pll_lock  = pll;
    bus.cdr_lock  = cdr;
    bus.force_rst = frc;
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget);
    int n;
    n = 0;
    while (bus.state !== s && n < budget) begin
      cyc(1);
      n++;
    end
    n_checks++;
    if (bus.state !== s) begin
      n_fail++;
      $display("FAIL wait_state: got st=%0d, want st=%0d within %0d cycles", bus.state, s, budget);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    arst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0);

    // Nominal bring-up (edges counted from PLL rise), then CDR drop/relock, then PLL+CDR drop together.
    vecs[0]  = mk(1, 0, 0,  6, 0, 0, 0, 0, 0, 0);
    vecs[1]  = mk(1, 0, 0,  1, 1, 0, 0, 0, 0, 0);
    vecs[2]  = mk(1, 0, 0, 19, 1, 0, 0, 0, 0, 0);
    vecs[3]  = mk(1, 0, 0,  1, 2, 1, 0, 0, 0, 0);
    vecs[4]  = mk(1, 1, 0,  6, 2, 1, 0, 0, 0, 0);
    vecs[5]  = mk(1, 1, 0,  1, 4, 1, 1, 0, 0, 0);
    vecs[6]  = mk(1, 1, 0,  4, 4, 1, 1, 0, 0, 0);
    vecs[7]  = mk(1, 1, 0,  1, 5, 1, 1, 1, 0, 0);
    vecs[8]  = mk(1, 0, 0,  2, 5, 1, 1, 1, 0, 0);
    vecs[9]  = mk(1, 0, 0,  1, 3, 0, 0, 0, 0, 1);
    vecs[10] = mk(1, 0, 0,  2, 3, 0, 0, 0, 0, 1);
    vecs[11] = mk(1, 0, 0,  1, 2, 1, 0, 0, 0, 1);
    vecs[12] = mk(1, 1, 0,  7, 4, 1, 1, 0, 0, 1);
    vecs[13] = mk(1, 1, 0,  5, 5, 1, 1, 1, 0, 1);
    vecs[14] = mk(0, 0, 0,  2, 5, 1, 1, 1, 0, 1);
    vecs[15] = mk(0, 0, 0,  1, 0, 0, 0, 0, 0, 0);

    cyc(3);
    chk("reset", pk(0, 0, 0, 0, 0, 0));
    arst_n = 1'b1;
    cyc(1);
    chk("reset_release", pk(0, 0, 0, 0, 0, 0));

    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].pll, vecs[i].cdr, vecs[i].frc);
      cyc(vecs[i].n);
      chk($sformatf("vec%0d", i),
          {vecs[i].st, vecs[i].pma, vecs[i].pcs, vecs[i].rdy, vecs[i].flt, vecs[i].rt});
    end

    // Glitch: three synced-high cycles must not count as a PLL lock.
    cyc(2);
    drive(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) begin
      if (i == 3) bus.pll_lock = 1'b0;
      cyc(1);
      chk($sformatf("glitch%0d", i), pk(0, 0, 0, 0, 0, 0));
    end

    // CDR never locks: two retries, then fault; force_rst recovers.
    drive(1'b1, 1'b0, 1'b0);
    cyc(27); chk("cdr_wait0",   pk(2, 1, 0, 0, 0, 0));
    cyc(49); chk("cdr_wait0_e", pk(2, 1, 0, 0, 0, 0));
    cyc(1);  chk("pulse1",      pk(3, 0, 0, 0, 0, 1));
    cyc(2);  chk("pulse1_e",    pk(3, 0, 0, 0, 0, 1));
    cyc(1);  chk("cdr_wait1",   pk(2, 1, 0, 0, 0, 1));
    cyc(49); chk("cdr_wait1_e", pk(2, 1, 0, 0, 0, 1));
    cyc(1);  chk("pulse2",      pk(3, 0, 0, 0, 0, 2));
    cyc(3);  chk("cdr_wait2",   pk(2, 1, 0, 0, 0, 2));
    cyc(49); chk("cdr_wait2_e", pk(2, 1, 0, 0, 0, 2));
    cyc(1);  chk("fault",       pk(6, 0, 0, 0, 1, 2));
    cyc(10); chk("fault_hold",  pk(6, 0, 0, 0, 1, 2));
    drive(1'b1, 1'b0, 1'b1);
    cyc(1);  chk("force_rst",   pk(0, 0, 0, 0, 0, 0));
    drive(1'b1, 1'b0, 1'b0);
    cyc(1);  chk("after_force", pk(1, 0, 0, 0, 0, 0));

    // Async reset mid PCS_REL, then a clean restart with both locks held high.
    drive(1'b1, 1'b1, 1'b0);
    wait_state(3'd4, 60);
    cyc(2);
    chk("pcs_rel_pre", pk(4, 1, 1, 0, 0, 0));
    #2 arst_n = 1'b0;
    #1 chk("arst_async", pk(0, 0, 0, 0, 0, 0));
    @(negedge clk);
    arst_n = 1'b1;
    chk("arst_release", pk(0, 0, 0, 0, 0, 0));
    cyc(6);  chk("restart_filt",   pk(0, 0, 0, 0, 0, 0));
    cyc(1);  chk("restart_settle", pk(1, 0, 0, 0, 0, 0));
    cyc(20); chk("restart_cdr",    pk(2, 1, 0, 0, 0, 0));
    cyc(1);  chk("restart_pcs",    pk(4, 1, 1, 0, 0, 0));
    cyc(5);  chk("restart_ready",  pk(5, 1, 1, 1, 0, 0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
